// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Multiplexed seven-segment scan controller for common-anode displays.
// Each digit owns one slot of PRESCALE clocks. The slot is split into 16
// sub-ticks: sub-tick 0 is a dark guard interval, and sub-ticks 1..brightness
// are lit. All inputs are captured once per frame so a frame is never torn.
module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int PRESCALE     = 1024,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] hex_data,
    input  logic [7*NUM_DIGITS-1:0] raw_seg,
    input  logic [NUM_DIGITS-1:0]   raw_sel,
    input  logic [NUM_DIGITS-1:0]   valid,
    input  logic [NUM_DIGITS-1:0]   blink,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [6:0]              digits,
    output logic                    dp_n,
    output logic                    frame_start
);

    // slot_cnt is held as {sub-tick, count within sub-tick}, which gives
    // t = slot_cnt / (PRESCALE/16) without a divider.
    localparam int SUB   = PRESCALE / 16;
    localparam int SUB_W = (SUB > 1) ? $clog2(SUB) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB - 1);
    localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
    localparam logic [SUB_W-1:0] SUB_ZERO = SUB_W'(0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [FRM_W-1:0] FRM_ONE  = FRM_W'(1);
    localparam logic [FRM_W-1:0] FRM_ZERO = FRM_W'(0);

    // Active-low seven-segment decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Scan counters
    logic [SUB_W-1:0] sub_cnt_r;
    logic [3:0]       tick_r;
    logic [IDX_W-1:0] idx_r;
    logic [FRM_W-1:0] frame_cnt_r;
    logic             blink_phase_r;

    // Frame snapshot
    logic [4*NUM_DIGITS-1:0] snap_hex_r;
    logic [7*NUM_DIGITS-1:0] snap_raw_r;
    logic [NUM_DIGITS-1:0]   snap_rawsel_r;
    logic [NUM_DIGITS-1:0]   snap_valid_r;
    logic [NUM_DIGITS-1:0]   snap_blink_r;
    logic [NUM_DIGITS-1:0]   snap_dp_r;
    logic [3:0]              snap_bright_r;

    // Registered pin drivers
    logic [NUM_DIGITS-1:0] anodes_r;
    logic [6:0]            digits_r;
    logic                  dp_n_r;

    // Next-state decision
    logic                  sub_wrap_s;
    logic                  slot_wrap_s;
    logic                  frame_wrap_s;
    logic                  boundary_s;
    logic [3:0]            nib_s;
    logic [6:0]            raw_s;
    logic                  rawsel_s;
    logic                  valid_s;
    logic                  blink_s;
    logic                  dp_s;
    logic                  lit_s;
    logic [NUM_DIGITS-1:0] anodes_nxt_s;
    logic [6:0]            digits_nxt_s;
    logic                  dp_n_nxt_s;

    assign sub_wrap_s   = (sub_cnt_r == SUB_LAST);
    assign slot_wrap_s  = sub_wrap_s && (tick_r == 4'd15);
    assign frame_wrap_s = slot_wrap_s && (idx_r == IDX_LAST);
    assign boundary_s   = (idx_r == IDX_ZERO) && (tick_r == 4'd0) && (sub_cnt_r == SUB_ZERO);

    // The counters sit at zero during reset. Gating with reset keeps the
    // pulse low while reset is held and lets it fire in the first cycle after release.
    assign frame_start = boundary_s & reset;

    assign anodes = anodes_r;
    assign digits = digits_r;
    assign dp_n   = dp_n_r;

    // Slot, digit and frame counters. The blink phase flips as the last
    // frame of a blink half-period ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sub_cnt_r     <= SUB_ZERO;
            tick_r        <= 4'd0;
            idx_r         <= IDX_ZERO;
            frame_cnt_r   <= FRM_ZERO;
            blink_phase_r <= 1'b0;
        end else begin
            sub_cnt_r <= sub_wrap_s ? SUB_ZERO : (sub_cnt_r + SUB_ONE);
            if (sub_wrap_s) begin
                tick_r <= tick_r + 4'd1;
            end
            if (slot_wrap_s) begin
                idx_r <= (idx_r == IDX_LAST) ? IDX_ZERO : (idx_r + IDX_ONE);
            end
            if (frame_wrap_s) begin
                if (frame_cnt_r == FRM_LAST) begin
                    frame_cnt_r   <= FRM_ZERO;
                    blink_phase_r <= ~blink_phase_r;
                end else begin
                    frame_cnt_r <= frame_cnt_r + FRM_ONE;
                end
            end
        end
    end

    // Capture every display input once, at the frame boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_hex_r    <= {(4*NUM_DIGITS){1'b0}};
            snap_raw_r    <= {(7*NUM_DIGITS){1'b0}};
            snap_rawsel_r <= {NUM_DIGITS{1'b0}};
            snap_valid_r  <= {NUM_DIGITS{1'b0}};
            snap_blink_r  <= {NUM_DIGITS{1'b0}};
            snap_dp_r     <= {NUM_DIGITS{1'b0}};
            snap_bright_r <= 4'd0;
        end else if (boundary_s) begin
            snap_hex_r    <= hex_data;
            snap_raw_r    <= raw_seg;
            snap_rawsel_r <= raw_sel;
            snap_valid_r  <= valid;
            snap_blink_r  <= blink;
            snap_dp_r     <= dp;
            snap_bright_r <= brightness;
        end
    end

    // Select the current digit's snapshot fields.
    always_comb begin
        nib_s    = 4'd0;
        raw_s    = 7'h7F;
        rawsel_s = 1'b0;
        valid_s  = 1'b0;
        blink_s  = 1'b0;
        dp_s     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_r == IDX_W'(i)) begin
                nib_s    = snap_hex_r[4*i +: 4];
                raw_s    = snap_raw_r[7*i +: 7];
                rawsel_s = snap_rawsel_r[i];
                valid_s  = snap_valid_r[i];
                blink_s  = snap_blink_r[i];
                dp_s     = snap_dp_r[i];
            end else begin
                nib_s = nib_s;
            end
        end
    end

    // Decide whether the current digit is lit and what it shows.
    always_comb begin
        lit_s = (tick_r != 4'd0) && (tick_r <= snap_bright_r) && valid_s &&
                !(blink_s && blink_phase_r);
        if (lit_s) begin
            digits_nxt_s = rawsel_s ? raw_s : hex_decode(nib_s);
            dp_n_nxt_s   = ~dp_s;
        end else begin
            digits_nxt_s = 7'h7F;
            dp_n_nxt_s   = 1'b1;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            anodes_nxt_s[i] = ~(lit_s && (idx_r == IDX_W'(i)));
        end
    end

    // Register the pin drivers so the anodes and segments switch cleanly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anodes_r <= {NUM_DIGITS{1'b1}};
            digits_r <= 7'h7F;
            dp_n_r   <= 1'b1;
        end else begin
            anodes_r <= anodes_nxt_s;
            digits_r <= digits_nxt_s;
            dp_n_r   <= dp_n_nxt_s;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (4 digits, 32-clock slots, 2-frame blink).
// Expected pins come from a cycle-count model: cycle c after reset release
// shows the decision made for scan position c-1, using the inputs captured at
// that frame's boundary.
module tb_display_scan_ctrl;
    localparam int N     = 4;
    localparam int PS    = 32;
    localparam int BF    = 2;
    localparam int FRAME = N * PS;
    localparam int SUBT  = PS / 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] hex_data = 16'h0;
    logic [27:0] raw_seg = 28'h0;
    logic [3:0]  raw_sel = 4'h0;
    logic [3:0]  valid = 4'h0;
    logic [3:0]  blink = 4'h0;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  brightness = 4'h0;
    logic [3:0]  anodes;
    logic [6:0]  digits;
    logic        dp_n;
    logic        frame_start;

    always #5 clk = ~clk;

    display_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(PS), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .hex_data(hex_data), .raw_seg(raw_seg),
        .raw_sel(raw_sel), .valid(valid), .blink(blink), .dp(dp),
        .brightness(brightness), .anodes(anodes), .digits(digits),
        .dp_n(dp_n), .frame_start(frame_start)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [6:0] hex_tbl [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model copy of the inputs captured at the latest frame boundary
    logic [15:0] m_hex;
    logic [27:0] m_raw;
    logic [3:0]  m_rawsel, m_valid, m_blink, m_dp, m_bright;

    logic [11:0] exp_v;
    logic        exp_fs;

    // Expected {anodes, digits, dp_n} in cycle c after release
    function automatic logic [11:0] expect_pins(input int c);
        int k, t, d, f;
        logic [3:0] an;
        logic [6:0] seg;
        logic dpn;
        bit lit;
        an = 4'hF; seg = 7'h7F; dpn = 1'b1;
        if (c >= 1) begin
            k = c - 1;
            t = (k % PS) / SUBT;
            d = (k / PS) % N;
            f = k / FRAME;
            lit = (t >= 1) && (t <= int'(m_bright)) && (m_valid[d] == 1'b1) &&
                  !((m_blink[d] == 1'b1) && (((f / BF) % 2) == 1));
            if (lit) begin
                an[d] = 1'b0;
                seg = m_rawsel[d] ? m_raw[7*d +: 7] : hex_tbl[m_hex[4*d +: 4]];
                dpn = ~m_dp[d];
            end
        end
        return {an, seg, dpn};
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic snap_if_boundary();
        if (cyc % FRAME == 0) begin
            m_hex = hex_data; m_raw = raw_seg; m_rawsel = raw_sel; m_valid = valid;
            m_blink = blink; m_dp = dp; m_bright = brightness;
        end
    endtask

    // Hold reset briefly, release it just after a rising edge and stop in cycle 0
    task automatic release_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        cyc = 0;
        m_hex = 16'h0; m_raw = 28'h0; m_rawsel = 4'h0; m_valid = 4'h0;
        m_blink = 4'h0; m_dp = 4'h0; m_bright = 4'h0;
    endtask

    task automatic randomize_inputs();
        hex_data = 16'($urandom); raw_seg = 28'($urandom); raw_sel = 4'($urandom);
        valid = 4'($urandom); blink = 4'($urandom); dp = 4'($urandom);
        brightness = 4'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b0; valid = 4'hF; brightness = 4'hF; hex_data = 16'($urandom);
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({anodes, digits, dp_n, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold got an=%b seg=%h dpn=%b fs=%b exp an=1111 seg=7f dpn=1 fs=0",
                         anodes, digits, dp_n, frame_start);
            end
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_fs got %b exp 1", frame_start);
        end
    endtask

    task automatic test_hex_scan();
        int fs_cnt, lit0;
        hex_data = 16'h1234; raw_sel = 4'h0; valid = 4'hF; blink = 4'h0; dp = 4'h0; brightness = 4'hF;
        release_reset();
        fs_cnt = 0; lit0 = 0;
        for (int i = 0; i <= 2 * FRAME; i++) begin
            if (i > 0) tick();
            exp_v = expect_pins(cyc); exp_fs = (cyc % FRAME == 0);
            checks++;
            if ({anodes, digits, dp_n, frame_start} !== {exp_v, exp_fs}) begin
                errors++;
                $display("FAIL hex_scan cyc=%0d got %b_%h_%b_%b exp %b", cyc, anodes, digits, dp_n, frame_start, {exp_v, exp_fs});
            end
            if (frame_start === 1'b1 && cyc < 2 * FRAME) fs_cnt++;
            if (cyc >= 1 && cyc <= FRAME && anodes[0] === 1'b0) lit0++;
            if (cyc == 3) begin
                checks++;
                if ({anodes, digits} !== {4'b1110, 7'h19}) begin
                    errors++;
                    $display("FAIL hex_slot0 got an=%b seg=%h exp an=1110 seg=19", anodes, digits);
                end
            end
            if (cyc == 2) begin
                checks++;
                if (anodes !== 4'hF) begin
                    errors++;
                    $display("FAIL hex_guard got an=%b exp 1111", anodes);
                end
            end
            if (cyc == 35 || cyc == 67 || cyc == 99) begin
                checks++;
                if (digits !== ((cyc == 35) ? 7'h30 : (cyc == 67) ? 7'h24 : 7'h79)) begin
                    errors++;
                    $display("FAIL hex_slots cyc=%0d got seg=%h", cyc, digits);
                end
            end
            snap_if_boundary();
        end
        checks++;
        if (fs_cnt != 2) begin errors++; $display("FAIL hex_fs_count got %0d exp 2", fs_cnt); end
        checks++;
        if (lit0 != 30) begin errors++; $display("FAIL hex_lit_len got %0d exp 30", lit0); end
    endtask

    task automatic test_brightness();
        int lit_cnt [N];
        int dark_bad;
        randomize_inputs();
        raw_sel = 4'h0; valid = 4'hF; blink = 4'h0; brightness = 4'd3;
        release_reset();
        foreach (lit_cnt[d]) lit_cnt[d] = 0;
        dark_bad = 0;
        for (int i = 0; i <= 2 * FRAME; i++) begin
            if (i > 0) tick();
            exp_v = expect_pins(cyc); exp_fs = (cyc % FRAME == 0);
            checks++;
            if ({anodes, digits, dp_n, frame_start} !== {exp_v, exp_fs}) begin
                errors++;
                $display("FAIL brightness cyc=%0d got %b_%h_%b_%b exp %b", cyc, anodes, digits, dp_n, frame_start, {exp_v, exp_fs});
            end
            for (int d = 0; d < N; d++) begin
                if (cyc >= 1 && cyc <= FRAME && anodes[d] === 1'b0) lit_cnt[d]++;
            end
            if (cyc > FRAME && anodes !== 4'hF) dark_bad++;
            if (cyc == 64) brightness = 4'd0;
            snap_if_boundary();
        end
        for (int d = 0; d < N; d++) begin
            checks++;
            if (lit_cnt[d] != 6) begin errors++; $display("FAIL bright3_len digit=%0d got %0d exp 6", d, lit_cnt[d]); end
        end
        checks++;
        if (dark_bad != 0) begin errors++; $display("FAIL bright0_dark got %0d lit cycles exp 0", dark_bad); end
    endtask

    task automatic test_raw_dp_valid();
        int lit2;
        randomize_inputs();
        raw_sel = 4'b0001; raw_seg[6:0] = 7'h3F; dp = 4'b0010; valid = 4'b1011;
        blink = 4'h0; brightness = 4'hF;
        release_reset();
        lit2 = 0;
        for (int i = 0; i <= FRAME; i++) begin
            if (i > 0) tick();
            exp_v = expect_pins(cyc); exp_fs = (cyc % FRAME == 0);
            checks++;
            if ({anodes, digits, dp_n, frame_start} !== {exp_v, exp_fs}) begin
                errors++;
                $display("FAIL raw_dp_valid cyc=%0d got %b_%h_%b_%b exp %b", cyc, anodes, digits, dp_n, frame_start, {exp_v, exp_fs});
            end
            if (anodes[2] === 1'b0) lit2++;
            if (cyc == 3) begin
                checks++;
                if ({anodes, digits, dp_n} !== {4'b1110, 7'h3F, 1'b1}) begin
                    errors++;
                    $display("FAIL raw_digit0 got an=%b seg=%h dpn=%b exp 1110 3f 1", anodes, digits, dp_n);
                end
            end
            if (cyc == 35) begin
                checks++;
                if ({anodes, digits, dp_n} !== {4'b1101, hex_tbl[hex_data[7:4]], 1'b0}) begin
                    errors++;
                    $display("FAIL dp_digit1 got an=%b seg=%h dpn=%b exp 1101 %h 0", anodes, digits, dp_n, hex_tbl[hex_data[7:4]]);
                end
            end
            snap_if_boundary();
        end
        checks++;
        if (lit2 != 0) begin errors++; $display("FAIL valid_digit2 got %0d lit cycles exp 0", lit2); end
    endtask

    task automatic test_blink();
        int lit0 [8];
        int lit1 [8];
        int f;
        randomize_inputs();
        blink = 4'b0010; valid = 4'hF; brightness = 4'hF;
        release_reset();
        foreach (lit1[j]) begin lit0[j] = 0; lit1[j] = 0; end
        for (int i = 0; i <= 8 * FRAME; i++) begin
            if (i > 0) tick();
            exp_v = expect_pins(cyc); exp_fs = (cyc % FRAME == 0);
            checks++;
            if ({anodes, digits, dp_n, frame_start} !== {exp_v, exp_fs}) begin
                errors++;
                $display("FAIL blink cyc=%0d got %b_%h_%b_%b exp %b", cyc, anodes, digits, dp_n, frame_start, {exp_v, exp_fs});
            end
            if (cyc >= 1) begin
                f = (cyc - 1) / FRAME;
                if (anodes[0] === 1'b0) lit0[f]++;
                if (anodes[1] === 1'b0) lit1[f]++;
            end
            snap_if_boundary();
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (lit1[j] != ((j == 2 || j == 3 || j == 6 || j == 7) ? 0 : 30)) begin
                errors++;
                $display("FAIL blink_digit1 frame=%0d got %0d lit cycles", j, lit1[j]);
            end
            checks++;
            if (lit0[j] != 30) begin
                errors++;
                $display("FAIL blink_digit0 frame=%0d got %0d lit cycles exp 30", j, lit0[j]);
            end
        end
    endtask

    task automatic test_snapshot();
        hex_data = 16'h1234; raw_sel = 4'h0; valid = 4'hF; blink = 4'h0; dp = 4'h0; brightness = 4'hF;
        release_reset();
        for (int i = 0; i <= 2 * FRAME; i++) begin
            if (i > 0) tick();
            exp_v = expect_pins(cyc); exp_fs = (cyc % FRAME == 0);
            checks++;
            if ({anodes, digits, dp_n, frame_start} !== {exp_v, exp_fs}) begin
                errors++;
                $display("FAIL snapshot cyc=%0d got %b_%h_%b_%b exp %b", cyc, anodes, digits, dp_n, frame_start, {exp_v, exp_fs});
            end
            if (cyc == 50 || cyc == 80 || cyc == 110 || cyc == 131 || cyc == 163) begin
                checks++;
                if (digits !== ((cyc == 50) ? 7'h30 : (cyc == 80) ? 7'h24 : (cyc == 110) ? 7'h79 :
                                (cyc == 131) ? 7'h21 : 7'h46)) begin
                    errors++;
                    $display("FAIL snapshot_digit cyc=%0d got seg=%h", cyc, digits);
                end
            end
            if (cyc == 40) hex_data = 16'hABCD;
            snap_if_boundary();
        end
    endtask

    task automatic test_random();
        randomize_inputs();
        release_reset();
        for (int i = 0; i <= 6 * FRAME; i++) begin
            if (i > 0) tick();
            exp_v = expect_pins(cyc); exp_fs = (cyc % FRAME == 0);
            checks++;
            if ({anodes, digits, dp_n, frame_start} !== {exp_v, exp_fs}) begin
                errors++;
                $display("FAIL random cyc=%0d got %b_%h_%b_%b exp %b", cyc, anodes, digits, dp_n, frame_start, {exp_v, exp_fs});
            end
            if ($urandom_range(0, 39) == 0) randomize_inputs();
            snap_if_boundary();
        end
    endtask

    task automatic test_reset_midframe();
        randomize_inputs();
        valid = 4'hF; blink = 4'h0; brightness = 4'hF;
        release_reset();
        for (int i = 1; i <= 80; i++) begin
            tick();
            snap_if_boundary();
        end
        checks++;
        if (anodes !== 4'b1011) begin
            errors++;
            $display("FAIL midframe_lit got an=%b exp 1011", anodes);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({anodes, digits, dp_n, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midframe_reset got an=%b seg=%h dpn=%b fs=%b exp 1111 7f 1 0", anodes, digits, dp_n, frame_start);
        end
        release_reset();
        for (int i = 0; i <= FRAME; i++) begin
            if (i > 0) tick();
            exp_v = expect_pins(cyc); exp_fs = (cyc % FRAME == 0);
            checks++;
            if ({anodes, digits, dp_n, frame_start} !== {exp_v, exp_fs}) begin
                errors++;
                $display("FAIL restart cyc=%0d got %b_%h_%b_%b exp %b", cyc, anodes, digits, dp_n, frame_start, {exp_v, exp_fs});
            end
            snap_if_boundary();
        end
    endtask

    initial begin
        test_reset();
        test_hex_scan();
        test_brightness();
        test_raw_dp_valid();
        test_blink();
        test_snapshot();
        test_random();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Parametrised multiplexed seven-segment scan controller for the keypad/security front panel. It replaces the fixed 8-position display driver. It drives NUM_DIGITS common-anode positions from per-digit hex or raw segment data. Each digit has its own enable, blink and decimal-point control. Global brightness is set by in-slot PWM, and a guard interval suppresses ghosting. Inputs are snapshotted once per frame, so a frame never shows a mix of old and new data.

## Interface
- NUM_DIGITS, 8: number of scanned positions, 2..16.
- PRESCALE, 1024: clocks per digit slot. Must be a multiple of 16 and at least 32.
- BLINK_FRAMES, 64: number of frames per blink half-period, at least 1.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset. While it is 0, all state is forced to reset values; it is released synchronously to clk.
- hex_data  in  4*NUM_DIGITS  nibble i = hex_data[4i+3:4i], value shown on digit i.
- raw_seg  in  7*NUM_DIGITS  raw active-low pattern for digit i, bits {g,f,e,d,c,b,a}.
- raw_sel  in  NUM_DIGITS  1 = digit i shows raw_seg; 0 = digit i shows decoded hex.
- valid  in  NUM_DIGITS  1 = digit i is enabled; 0 = digit i is always dark.
- blink  in  NUM_DIGITS  1 = digit i is dark during the blink-off phase.
- dp  in  NUM_DIGITS  1 = decimal point of digit i is lit.
- brightness  in  4  0 = dark; 15 = maximum.
- anodes  out  NUM_DIGITS  active-low digit enables; at most one bit is 0.
- digits  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp_n  out  1  active-low decimal point.
- frame_start  out  1  one-cycle pulse when the snapshot loads.

## Operation
- Counters:
  - slot_cnt runs 0..PRESCALE-1.
  - idx runs 0..NUM_DIGITS-1. It increments when slot_cnt wraps, and wraps itself from NUM_DIGITS-1 to 0.
  - frame_cnt runs 0..BLINK_FRAMES-1. It advances on each frame boundary, and blink_phase toggles when it wraps.
- Frame boundary: the cycle with idx==0 and slot_cnt==0. This includes the first cycle after reset release.
  - On a frame boundary, hex_data, raw_seg, raw_sel, valid, blink, dp and brightness load into the snapshot registers.
  - frame_start is 1 in that same cycle.
- All display decisions use the snapshot only. Changing inputs mid-frame has no visible effect until the next frame.
- Sub-tick: t = slot_cnt / (PRESCALE/16), range 0..15.
  - t==0 is the guard interval: all anodes are off.
- Anode idx is driven low iff all of the following hold:
  - t >= 1
  - t <= brightness
  - valid[idx] == 1
  - not (blink[idx] == 1 and blink_phase == 1)
- Otherwise all anodes are 1. When no anode is driven low, digits = 7'h7F and dp_n = 1.
- When an anode is driven low:
  - digits = raw_seg[idx] if raw_sel[idx] is 1, else the hex decode of hex_data[idx].
  - dp_n = ~dp[idx].
- Hex decode (active-low, {g..a}):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30
  - 4 = 19, 5 = 12, 6 = 02, 7 = 78
  - 8 = 00, 9 = 10, A = 08, b = 03
  - C = 46, d = 21, E = 06, F = 0E (hex)
- Reset values:
  - Outputs: anodes all 1, digits 7'h7F, dp_n 1, frame_start 0.
  - State: counters 0, blink_phase 0, snapshot 0 (everything dark).

## Timing
- anodes, digits and dp_n are registered. They reflect the counter state of the previous cycle, so latency from counter state to pins is 1 cycle.
- frame_start is combinational from the counters. It is high in the load cycle itself.
- Lit time per slot is brightness*(PRESCALE/16) clocks. Frame length is NUM_DIGITS*PRESCALE clocks.
- Guard: at every slot change, all anodes are off for PRESCALE/16 clocks before the new digit lights. No two anodes are ever 0 in the same cycle.
- A change to brightness takes effect at the next frame boundary.
- Reset asserted mid-frame:
  - Outputs go to reset values asynchronously, within the same cycle.
  - After release, scanning restarts at idx 0 with frame_start.

## Test plan
Bench parameters for all scenarios: NUM_DIGITS=4, PRESCALE=32, BLINK_FRAMES=2.
- **Reset:** hold reset=0 for 5 cycles with valid=F and brightness=15 -> anodes=F, digits=7F and dp_n=1 throughout. On the first cycle after release, frame_start=1.
- **Hex scan:** hex_data=16'h1234, valid=F, brightness=15.
  - Slot 0: anodes=1110 and digits=19 ("4") for 30 cycles, starting 3 cycles into the slot (2 guard cycles, 1 register cycle).
  - Slots 1, 2, 3: digits=30, 24, 79 respectively.
  - A frame_start pulse occurs every 128 cycles.
- **Brightness:** brightness=3 -> each anode is low for exactly 6 cycles per slot. brightness=0 -> anodes=F for an entire frame.
- **Raw / dp / valid:** raw_sel=0001, raw_seg[0]=7'h3F, dp=0010, valid=1011.
  - Digit 0 shows 3F.
  - Digit 1 shows its hex decode with dp_n=0.
  - Digit 2 never lights.
- **Blink:** blink=0010, valid=F -> digit 1 is dark in frames 2, 3, 6, 7 and lit in frames 0, 1, 4, 5. The other digits are unaffected.
- **Snapshot / reset mid-frame:**
  - Change hex_data from 1234 to ABCD during slot 1 -> slots 1..3 still show 3, 2, 1; ABCD appears from the next frame_start.
  - Assert reset during slot 2 -> anodes=F in the same cycle.
